// File: rtl/board_renderer_if.sv
// Back-board write channel between game logic (master) and board_renderer (slave).
// Carries write/clear requests and the one-cycle accept/reject pulses.
interface board_renderer_if;
  logic       wr_en;
  logic [2:0] wr_col;
  logic [2:0] wr_row;
  logic [1:0] wr_piece;
  logic       clr;
  logic       wr_ack;
  logic       wr_err;

  modport master (
    output wr_en, wr_col, wr_row, wr_piece, clr,
    input  wr_ack, wr_err
  );

  modport slave (
    input  wr_en, wr_col, wr_row, wr_piece, clr,
    output wr_ack, wr_err
  );
endinterface

// File: rtl/board_renderer.sv
// Per-pixel colour generator for the Connect Four board: double-buffered 7x6 board, 2-cycle pipeline.
// Optional macro CURSOR_HIGHLIGHT_EN adds a drop-cursor piece in the cell-high strip above the board.
module board_renderer #(
  parameter int X0        = 96,
  parameter int Y0        = 64,
  parameter int CELL_LOG2 = 6,
  parameter int RADIUS    = 26
) (
  input  logic            CLOCK_25,
  input  logic            RESET_N,
  input  logic [9:0]      x_in,
  input  logic [9:0]      y_in,
  input  logic            current_buffer,
  board_renderer_if.slave wr,
`ifdef CURSOR_HIGHLIGHT_EN
  input  logic [2:0]      cursor_col,
  input  logic [1:0]      cursor_piece,
`endif
  output logic            frame_commit,
  output logic [23:0]     c_out
);
  localparam int NCOLS  = 7;
  localparam int NROWS  = 6;
  localparam int NCELLS = NCOLS * NROWS;
  localparam int CELL   = 1 << CELL_LOG2;
  localparam int SQ_W   = 2 * (CELL_LOG2 + 1);
  localparam logic [SQ_W-1:0] R2 = SQ_W'(RADIUS * RADIUS);
  localparam logic [23:0] COLOUR_BG     = 24'h34495E;
  localparam logic [23:0] COLOUR_BORDER = 24'hFFFFFF;
  localparam logic [23:0] COLOUR_RED    = 24'hF1948A;
  localparam logic [23:0] COLOUR_YELLOW = 24'hF9E79F;

  // ---------------- board storage and write handshake ----------------
  logic [1:0]        back_reg  [NCELLS];
  logic [1:0]        front_reg [NCELLS];
  logic              prev_buffer_reg;
  logic              commit;
  logic              wr_legal;
  logic              wr_valid;
  logic              wr_bad;
  logic [5:0]        wr_idx;
  logic [NCELLS-1:0] cell_we;
  logic              wr_ack_reg;
  logic              wr_err_reg;
  logic              frame_commit_reg;

  assign wr_legal = (wr.wr_col <= 3'd6) && (wr.wr_row <= 3'd5) && (wr.wr_piece != 2'd3);
  assign wr_valid = wr.wr_en && !wr.clr && wr_legal;
  assign wr_bad   = wr.wr_en && !wr.clr && !wr_legal;
  assign wr_idx   = 6'(wr.wr_col) * 6'd6 + 6'(wr.wr_row);
  assign commit   = current_buffer ^ prev_buffer_reg;

  generate
    for (genvar gi = 0; gi < NCELLS; gi++) begin : g_cell_we
      assign cell_we[gi] = wr_valid && (wr_idx == 6'(gi));
    end
  endgenerate

  // Front copies the pre-edge back value, so a write landing in the commit cycle waits a frame.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NCELLS; i++) begin
        back_reg[i]  <= 2'd0;
        front_reg[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < NCELLS; i++) begin
        if (commit) front_reg[i] <= back_reg[i];
        if (wr.clr) back_reg[i] <= 2'd0;
        else if (cell_we[i]) back_reg[i] <= wr.wr_piece;
      end
    end
  end

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      prev_buffer_reg  <= 1'b0;
      wr_ack_reg       <= 1'b0;
      wr_err_reg       <= 1'b0;
      frame_commit_reg <= 1'b0;
    end else begin
      prev_buffer_reg  <= current_buffer;
      wr_ack_reg       <= wr_valid;
      wr_err_reg       <= wr_bad;
      frame_commit_reg <= commit;
    end
  end

  assign wr.wr_ack    = wr_ack_reg;
  assign wr.wr_err    = wr_err_reg;
  assign frame_commit = frame_commit_reg;

  // ---------------- pixel pipeline, stage 1 ----------------
  // Bit 10 of the 11-bit differences is the sign: set means left of / above the board.
  logic [10:0] rel_x;
  logic [10:0] rel_y;
  logic [10:0] cell_x;
  logic [10:0] cell_y;
  logic        x_in_cols;
  logic        y_in_rows;
  logic        in_board;

  assign rel_x     = {1'b0, x_in} - 11'(X0);
  assign rel_y     = {1'b0, y_in} - 11'(Y0);
  assign cell_x    = rel_x >> CELL_LOG2;
  assign cell_y    = rel_y >> CELL_LOG2;
  assign x_in_cols = !rel_x[10] && (cell_x < 11'(NCOLS));
  assign y_in_rows = !rel_y[10] && (cell_y < 11'(NROWS));
  assign in_board  = x_in_cols && y_in_rows;

  logic                 s1_in_board_reg;
  logic [2:0]           s1_col_reg;
  logic [2:0]           s1_vrow_reg;
  logic [CELL_LOG2-1:0] s1_lx_reg;
  logic [CELL_LOG2-1:0] s1_ly_reg;

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_in_board_reg <= 1'b0;
      s1_col_reg      <= 3'd0;
      s1_vrow_reg     <= 3'd0;
      s1_lx_reg       <= '0;
      s1_ly_reg       <= '0;
    end else begin
      s1_in_board_reg <= in_board;
      s1_col_reg      <= in_board ? cell_x[2:0] : 3'd0;
      s1_vrow_reg     <= in_board ? cell_y[2:0] : 3'd0;
      s1_lx_reg       <= rel_x[CELL_LOG2-1:0];
      s1_ly_reg       <= rel_y[CELL_LOG2-1:0];
    end
  end

`ifdef CURSOR_HIGHLIGHT_EN
  logic       in_strip;
  logic       s1_cur_reg;
  logic [1:0] s1_cur_piece_reg;

  // The strip is the single cell row directly above the board, i.e. rel_y in [-CELL, -1].
  assign in_strip = rel_y[10] && (rel_y >= 11'(2048 - CELL));

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_cur_reg       <= 1'b0;
      s1_cur_piece_reg <= 2'd0;
    end else begin
      s1_cur_reg       <= in_strip && x_in_cols && (cell_x[2:0] == cursor_col);
      s1_cur_piece_reg <= cursor_piece;
    end
  end
`endif

  // ---------------- pixel pipeline, stage 2 ----------------
  logic signed [CELL_LOG2:0] dx;
  logic signed [CELL_LOG2:0] dy;
  logic signed [SQ_W-1:0]    dx_sq;
  logic signed [SQ_W-1:0]    dy_sq;
  logic [SQ_W-1:0]           d2;
  logic                      in_circle;
  logic                      on_border;
  logic [5:0]                rd_idx;
  logic [1:0]                piece;
  logic [23:0]               colour_next;
  logic [23:0]               c_out_reg;

  assign dx        = {1'b0, s1_lx_reg} - {2'b01, {(CELL_LOG2-1){1'b0}}};
  assign dy        = {1'b0, s1_ly_reg} - {2'b01, {(CELL_LOG2-1){1'b0}}};
  assign dx_sq     = dx * dx;
  assign dy_sq     = dy * dy;
  assign d2        = $unsigned(dx_sq) + $unsigned(dy_sq);
  assign in_circle = (d2 <= R2);
  assign on_border = (s1_lx_reg == '0) || (s1_lx_reg == '1) ||
                     (s1_ly_reg == '0) || (s1_ly_reg == '1);
  // Board rows count up from the bottom while screen rows count down.
  assign rd_idx    = 6'(s1_col_reg) * 6'd6 + 6'(3'd5 - s1_vrow_reg);
  assign piece     = front_reg[rd_idx];

  always_comb begin
    colour_next = COLOUR_BG;
    if (s1_in_board_reg) begin
      if (on_border)                          colour_next = COLOUR_BORDER;
      else if (in_circle && piece == 2'd1)    colour_next = COLOUR_RED;
      else if (in_circle && piece == 2'd2)    colour_next = COLOUR_YELLOW;
    end
`ifdef CURSOR_HIGHLIGHT_EN
    else if (s1_cur_reg && in_circle) begin
      if (s1_cur_piece_reg == 2'd1)           colour_next = COLOUR_RED;
      else if (s1_cur_piece_reg == 2'd2)      colour_next = COLOUR_YELLOW;
    end
`endif
  end

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) c_out_reg <= 24'd0;
    else          c_out_reg <= colour_next;
  end

  assign c_out = c_out_reg;
endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer: constant pixel table, hand-written board sequences,
// then randomized traffic against a geometric reference model of the board and its colours.
module tb_board_renderer;
  localparam logic [23:0] BG = 24'h34495E;
  localparam logic [23:0] WH = 24'hFFFFFF;
  localparam logic [23:0] RD = 24'hF1948A;
  localparam logic [23:0] YL = 24'hF9E79F;

  logic        CLOCK_25 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic [9:0]  x_in     = 10'd0;
  logic [9:0]  y_in     = 10'd0;
  logic        current_buffer = 1'b0;
  logic        frame_commit;
  logic [23:0] c_out;
`ifdef CURSOR_HIGHLIGHT_EN
  logic [2:0]  cursor_col   = 3'd0;
  logic [1:0]  cursor_piece = 2'd0;
`endif

  board_renderer_if bus ();

  board_renderer dut (
    .CLOCK_25       (CLOCK_25),
    .RESET_N        (RESET_N),
    .x_in           (x_in),
    .y_in           (y_in),
    .current_buffer (current_buffer),
    .wr             (bus),
`ifdef CURSOR_HIGHLIGHT_EN
    .cursor_col     (cursor_col),
    .cursor_piece   (cursor_piece),
`endif
    .frame_commit   (frame_commit),
    .c_out          (c_out)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  int total = 0;
  int bad   = 0;

  // Reference model: board contents as [column][row], row 0 at the bottom.
  int back_m  [7][6];
  int front_m [7][6];
  int m_prev = 0;
  logic [23:0] pipe [$];

  typedef struct {
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs [8];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_colour(int x, int y, int ccol, int cpiece);
    int lx, ly, d2, p;
    if (x < 96 || x >= 96 + 7 * 64) return BG;
    lx = (x - 96) % 64;
    if (y >= 64 && y < 64 + 6 * 64) begin
      ly = (y - 64) % 64;
      if (lx == 0 || lx == 63 || ly == 0 || ly == 63) return WH;
      d2 = (lx - 32) * (lx - 32) + (ly - 32) * (ly - 32);
      p  = front_m[(x - 96) / 64][5 - (y - 64) / 64];
      if (d2 <= 26 * 26 && p == 1) return RD;
      if (d2 <= 26 * 26 && p == 2) return YL;
      return BG;
    end
`ifdef CURSOR_HIGHLIGHT_EN
    if (y < 64 && (x - 96) / 64 == ccol && (cpiece == 1 || cpiece == 2)) begin
      d2 = (lx - 32) * (lx - 32) + (y - 32) * (y - 32);
      if (d2 <= 26 * 26) return (cpiece == 1) ? RD : YL;
    end
`endif
    return BG;
  endfunction

  function automatic int cur_col();
`ifdef CURSOR_HIGHLIGHT_EN
    return int'(cursor_col);
`else
    return 0;
`endif
  endfunction

  function automatic int cur_piece();
`ifdef CURSOR_HIGHLIGHT_EN
    return int'(cursor_piece);
`else
    return 0;
`endif
  endfunction

  // One clock: update the model with the inputs held across the edge, then check all outputs.
  task automatic step();
    int legal, exp_ack, exp_err, exp_fc;
    logic [23:0] e;
    @(posedge CLOCK_25);
    legal   = (bus.wr_col <= 6 && bus.wr_row <= 5 && bus.wr_piece != 3) ? 1 : 0;
    exp_ack = (bus.wr_en && !bus.clr && legal == 1) ? 1 : 0;
    exp_err = (bus.wr_en && !bus.clr && legal == 0) ? 1 : 0;
    exp_fc  = (int'(current_buffer) != m_prev) ? 1 : 0;
    if (exp_fc == 1) front_m = back_m;
    if (bus.clr) begin
      foreach (back_m[c, r]) back_m[c][r] = 0;
    end else if (exp_ack == 1) begin
      back_m[bus.wr_col][bus.wr_row] = int'(bus.wr_piece);
    end
    m_prev = int'(current_buffer);
    pipe.push_back(model_colour(int'(x_in), int'(y_in), cur_col(), cur_piece()));
    @(negedge CLOCK_25);
    check("wr_ack", 32'(bus.wr_ack), 32'(exp_ack));
    check("wr_err", 32'(bus.wr_err), 32'(exp_err));
    check("frame_commit", 32'(frame_commit), 32'(exp_fc));
    if (pipe.size() >= 2) begin
      e = pipe.pop_front();
      check("c_out", 32'(c_out), 32'(e));
    end
  endtask

  task automatic show(int x, int y);
    x_in = 10'(x);
    y_in = 10'(y);
    step();
    step();
  endtask

  task automatic write_req(int col, int row, int piece, int do_clr);
    bus.wr_en    = 1'b1;
    bus.wr_col   = 3'(col);
    bus.wr_row   = 3'(row);
    bus.wr_piece = 2'(piece);
    bus.clr      = 1'(do_clr);
    step();
    $display("write col=%0d row=%0d piece=%0d clr=%0d -> ack=%0b err=%0b",
             col, row, piece, do_clr, bus.wr_ack, bus.wr_err);
    bus.wr_en = 1'b0;
    bus.clr   = 1'b0;
  endtask

  task automatic do_commit();
    current_buffer = ~current_buffer;
    step();
    $display("commit buffer=%0b -> frame_commit=%0b", current_buffer, frame_commit);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_other;
    bus.wr_en = 1'b0; bus.wr_col = 3'd0; bus.wr_row = 3'd0; bus.wr_piece = 2'd0; bus.clr = 1'b0;
    foreach (back_m[c, r]) begin back_m[c][r] = 0; front_m[c][r] = 0; end

    vecs[0] = '{128,  96, BG};
    vecs[1] = '{ 96, 200, WH};
    vecs[2] = '{127, 127, WH};
    vecs[3] = '{ 50,  50, BG};
    vecs[4] = '{543, 447, WH};
    vecs[5] = '{544, 200, BG};
    vecs[6] = '{128, 416, BG};
    vecs[7] = '{160, 300, WH};

    // Reset state
    repeat (2) @(negedge CLOCK_25);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
    check("rst_wr_err", 32'(bus.wr_err), 32'd0);
    check("rst_frame_commit", 32'(frame_commit), 32'd0);
    RESET_N = 1'b1;

    // Empty-board sweep: only background and cell borders may appear
    n_other = 0;
    for (int y = 0; y < 525; y += 10) begin
      for (int x = 0; x < 800; x += 4) begin
        x_in = 10'(x);
        y_in = 10'(y);
        step();
        if (c_out !== BG && c_out !== WH) n_other++;
      end
    end
    check("sweep_palette", 32'(n_other), 32'd0);

    for (int i = 0; i < 8; i++) begin
      show(vecs[i].x, vecs[i].y);
      $display("pixel (%0d,%0d) -> %h", vecs[i].x, vecs[i].y, c_out);
      check("table_pixel", 32'(c_out), 32'(vecs[i].exp));
    end

    // Red piece at bottom-left appears only after commit
    write_req(0, 0, 1, 0);
    check("t2_ack", 32'(bus.wr_ack), 32'd1);
    show(128, 416);
    check("t2_before_commit", 32'(c_out), 32'(BG));
    do_commit();
    check("t2_commit_pulse", 32'(frame_commit), 32'd1);
    show(128, 416);
    check("t2_red", 32'(c_out), 32'(RD));
    show(128, 96);
    check("t2_top_left", 32'(c_out), 32'(BG));

    // Rejected requests
    write_req(7, 0, 2, 0);
    check("t3_err_col", 32'(bus.wr_err), 32'd1);
    check("t3_noack_col", 32'(bus.wr_ack), 32'd0);
    write_req(0, 0, 3, 0);
    check("t3_err_piece", 32'(bus.wr_err), 32'd1);
    do_commit();
    show(128, 416);
    check("t3_unchanged", 32'(c_out), 32'(RD));

    // clr beats a simultaneous write
    write_req(3, 2, 2, 1);
    check("t4_no_ack", 32'(bus.wr_ack), 32'd0);
    check("t4_no_err", 32'(bus.wr_err), 32'd0);
    do_commit();
    show(320, 288);
    check("t4_cell_empty", 32'(c_out), 32'(BG));
    show(128, 416);
    check("t4_cleared", 32'(c_out), 32'(BG));

    // Write coinciding with a buffer toggle lands on the following commit
    current_buffer = ~current_buffer;
    write_req(1, 0, 2, 0);
    check("t5_ack", 32'(bus.wr_ack), 32'd1);
    check("t5_commit_pulse", 32'(frame_commit), 32'd1);
    show(192, 416);
    check("t5_absent", 32'(c_out), 32'(BG));
    do_commit();
    show(192, 416);
    check("t5_present", 32'(c_out), 32'(YL));

    // Asynchronous reset mid-line
    show(192, 416);
    #5;
    RESET_N = 1'b0;
    #1;
    check("t6_c_out_async", 32'(c_out), 32'd0);
    foreach (back_m[c, r]) begin back_m[c][r] = 0; front_m[c][r] = 0; end
    m_prev = 0;
    pipe.delete();
    repeat (2) @(negedge CLOCK_25);
    check("t6_c_out_held", 32'(c_out), 32'd0);
    RESET_N = 1'b1;
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        show(96 + 64 * c + 32, 64 + 64 * (5 - r) + 32);
        check("t6_empty_cell", 32'(c_out), 32'(BG));
      end
    end

`ifdef CURSOR_HIGHLIGHT_EN
    cursor_col   = 3'd6;
    cursor_piece = 2'd2;
    show(512, 32);
    check("cursor_yellow", 32'(c_out), 32'(YL));
    show(448, 32);
    check("cursor_other_col", 32'(c_out), 32'(BG));
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      x_in         = 10'($urandom_range(0, 799));
      y_in         = 10'($urandom_range(0, 524));
      bus.wr_en    = 1'($urandom_range(0, 3) == 0);
      bus.wr_col   = 3'($urandom_range(0, 7));
      bus.wr_row   = 3'($urandom_range(0, 7));
      bus.wr_piece = 2'($urandom_range(0, 3));
      bus.clr      = 1'($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) current_buffer = ~current_buffer;
`ifdef CURSOR_HIGHLIGHT_EN
      cursor_col   = 3'($urandom_range(0, 7));
      cursor_piece = 2'($urandom_range(0, 3));
`endif
      step();
    end
    bus.wr_en = 1'b0;
    bus.clr   = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
